// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between
// the IF-stage fetch and the MEM-stage data access. Data accesses win ties,
// each requester is served at most once per pipeline step, and stall_o holds
// the pipeline until every pending request of the step has completed.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  lat_cnt_q;
  logic              if_done_q;
  logic              dm_done_q;
  logic [31:0]       stall_cnt_q;
  logic              pend_if;
  logic              pend_dm;
  logic              grant_if;
  logic              grant_dm;
  logic              finish_if;
  logic              finish_dm;

  assign pend_if     = if_req_i & ~if_done_q;
  assign pend_dm     = dm_req_i & ~dm_done_q;
  assign stall_o     = pend_if | pend_dm;
  assign stall_cnt_o = stall_cnt_q;

  // Next-state decode: grant a pending requester from IDLE (data first),
  // and finish a busy access once the latency counter has run out.
  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    finish_if = 1'b0;
    finish_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_dm) begin
          state_d  = BUSY_DM;
          grant_dm = 1'b1;
        end else if (pend_if) begin
          state_d  = BUSY_IF;
          grant_if = 1'b1;
        end
      end
      BUSY_IF: begin
        if (lat_cnt_q == '0) begin
          state_d   = IDLE;
          finish_if = 1'b1;
        end
      end
      BUSY_DM: begin
        if (lat_cnt_q == '0) begin
          state_d   = IDLE;
          finish_dm = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory-side registers: one-cycle strobe, address/data latched on grant,
  // held while the bus is idle.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_en_o <= grant_if | grant_dm;
      if (grant_dm) begin
        mem_we_o    <= dm_we_i;
        mem_addr_o  <= dm_addr_i;
        mem_wdata_o <= dm_wdata_i;
      end else if (grant_if) begin
        mem_we_o   <= 1'b0;
        mem_addr_o <= if_addr_i;
      end
    end
  end

  // Latency counter: loaded on grant, counts down to the read-data sample.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      lat_cnt_q <= '0;
    end else if (grant_if | grant_dm) begin
      lat_cnt_q <= CNT_W'(MEM_LAT);
    end else if (state_q != IDLE && lat_cnt_q != '0) begin
      lat_cnt_q <= lat_cnt_q - CNT_W'(1);
    end
  end

  // Return path: capture memory data and pulse the matching valid.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      if_rdata_o <= '0;
      if_valid_o <= 1'b0;
      dm_rdata_o <= '0;
      dm_valid_o <= 1'b0;
    end else begin
      if_valid_o <= finish_if;
      dm_valid_o <= finish_dm;
      if (finish_if) if_rdata_o <= mem_rdata_i;
      if (finish_dm) dm_rdata_o <= mem_rdata_i;
    end
  end

  // Done flags: cleared when the pipeline advances, set on completion.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
    end else begin
      if (!stall_o) begin
        if_done_q <= 1'b0;
        dm_done_q <= 1'b0;
      end
      if (finish_if) if_done_q <= 1'b1;
      if (finish_dm) dm_done_q <= 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the IF/DM memory arbiter against a
// simple fixed-latency memory model, MEM_LAT = 2.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic [31:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_rdata_o (if_rdata),
    .if_valid_o (if_valid),
    .dm_req_i   (dm_req),
    .dm_we_i    (dm_we),
    .dm_addr_i  (dm_addr),
    .dm_wdata_i (dm_wdata),
    .dm_rdata_o (dm_rdata),
    .dm_valid_o (dm_valid),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .stall_o    (stall),
    .stall_cnt_o(stall_cnt)
  );

  // Memory model: unwritten words read as {16'hC0DE, addr[15:0]}; reads
  // come back MEM_LAT cycles after the strobe, garbage marker otherwise.
  bit   [31:0] store   [0:255];
  bit          written [0:255];
  logic [31:0] rd_pipe [0:MEM_LAT-1];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (written[a[9:2]]) return store[a[9:2]];
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory behaviour on each clock edge.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      store[mem_addr[9:2]]   <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hBAD0BAD0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd);
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_we    = dw;
    dm_addr  = da;
    dm_wdata = dd;
    #1;
  endtask

  // Hold reset for two edges, then release it; the caller's window is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  int n_if;
  int n_dm;
  int n_en;
  logic stall_at8;

  // Directed sequence.
  initial begin
    $display("[TB] start");
    do_reset();
    check_output("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check_output("rst_dm_valid", {31'b0, dm_valid}, 32'h0);
    check_output("rst_stall", {31'b0, stall}, 32'h0);
    check_output("rst_stall_cnt", stall_cnt, 32'h0);

    // Lone fetch.
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    check_output("t1_stall_c0", {31'b0, stall}, 32'h1);
    check_output("t1_mem_en_c0", {31'b0, mem_en}, 32'h0);
    step();
    check_output("t1_mem_en_c1", {31'b0, mem_en}, 32'h1);
    check_output("t1_mem_addr_c1", mem_addr, 32'h40);
    check_output("t1_mem_we_c1", {31'b0, mem_we}, 32'h0);
    step();
    check_output("t1_mem_en_c2", {31'b0, mem_en}, 32'h0);
    step();
    check_output("t1_if_valid_c3", {31'b0, if_valid}, 32'h0);
    check_output("t1_stall_c3", {31'b0, stall}, 32'h1);
    step();
    check_output("t1_if_valid_c4", {31'b0, if_valid}, 32'h1);
    check_output("t1_if_rdata_c4", if_rdata, 32'hC0DE0040);
    check_output("t1_stall_c4", {31'b0, stall}, 32'h0);
    apply_stimulus(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_output("t1_if_valid_c5", {31'b0, if_valid}, 32'h0);
    check_output("t1_stall_cnt", stall_cnt, 32'd4);

    // Both requests together: data access first, then fetch.
    do_reset();
    apply_stimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);
    step();
    check_output("t2_mem_en_c1", {31'b0, mem_en}, 32'h1);
    check_output("t2_mem_addr_c1", mem_addr, 32'h100);
    step();
    step();
    step();
    check_output("t2_dm_valid_c4", {31'b0, dm_valid}, 32'h1);
    check_output("t2_dm_rdata_c4", dm_rdata, 32'hC0DE0100);
    check_output("t2_if_valid_c4", {31'b0, if_valid}, 32'h0);
    check_output("t2_stall_c4", {31'b0, stall}, 32'h1);
    step();
    check_output("t2_mem_en_c5", {31'b0, mem_en}, 32'h1);
    check_output("t2_mem_addr_c5", mem_addr, 32'h44);
    check_output("t2_dm_valid_c5", {31'b0, dm_valid}, 32'h0);
    step();
    step();
    check_output("t2_stall_c7", {31'b0, stall}, 32'h1);
    step();
    check_output("t2_if_valid_c8", {31'b0, if_valid}, 32'h1);
    check_output("t2_if_rdata_c8", if_rdata, 32'hC0DE0044);
    check_output("t2_stall_c8", {31'b0, stall}, 32'h0);
    check_output("t2_stall_cnt", stall_cnt, 32'd8);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Store, then load the same word back.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step();
    check_output("t3_mem_en_c1", {31'b0, mem_en}, 32'h1);
    check_output("t3_mem_we_c1", {31'b0, mem_we}, 32'h1);
    check_output("t3_mem_addr_c1", mem_addr, 32'h10);
    check_output("t3_mem_wdata_c1", mem_wdata, 32'hDEADBEEF);
    step();
    step();
    step();
    check_output("t3_dm_valid_c4", {31'b0, dm_valid}, 32'h1);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    check_output("t3_load_we", {31'b0, mem_we}, 32'h0);
    step();
    step();
    step();
    check_output("t3_load_valid", {31'b0, dm_valid}, 32'h1);
    check_output("t3_load_rdata", dm_rdata, 32'hDEADBEEF);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Both requests held: one service each per stall window.
    apply_stimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h200, 32'h0);
    n_if = 0;
    n_dm = 0;
    n_en = 0;
    stall_at8 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (if_valid) n_if++;
      if (dm_valid) n_dm++;
      if (mem_en) n_en++;
      if (i == 8) stall_at8 = stall;
    end
    check_output("t4_if_served", n_if, 32'd1);
    check_output("t4_dm_served", n_dm, 32'd1);
    check_output("t4_mem_en_count", n_en, 32'd2);
    check_output("t4_stall_c8", {31'b0, stall_at8}, 32'h0);
    check_output("t4_stall_c9", {31'b0, stall}, 32'h1);
    step();
    check_output("t4_next_mem_en", {31'b0, mem_en}, 32'h1);
    check_output("t4_next_addr", mem_addr, 32'h200);
    // Withdraw both mid-access: the data access still completes.
    apply_stimulus(1'b0, 32'h48, 1'b0, 1'b0, 32'h200, 32'h0);
    step();
    step();
    step();
    check_output("t4_withdrawn_valid", {31'b0, dm_valid}, 32'h1);
    check_output("t4_withdrawn_rdata", dm_rdata, 32'hC0DE0200);
    step();
    step();
    check_output("t4_idle_mem_en", {31'b0, mem_en}, 32'h0);
    check_output("t4_idle_addr_hold", mem_addr, 32'h200);

    // Reset in the middle of a fetch aborts it.
    apply_stimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_output("t5_mem_en_c1", {31'b0, mem_en}, 32'h1);
    step();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_output("t5_rst_mem_en", {31'b0, mem_en}, 32'h0);
    check_output("t5_rst_mem_addr", mem_addr, 32'h0);
    check_output("t5_rst_if_valid", {31'b0, if_valid}, 32'h0);
    check_output("t5_rst_if_rdata", if_rdata, 32'h0);
    check_output("t5_rst_stall_cnt", stall_cnt, 32'h0);
    rst_n = 1'b1;
    n_if = 0;
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (if_valid) n_if++;
      if (mem_en) n_en++;
    end
    check_output("t5_no_if_valid", n_if, 32'd0);
    check_output("t5_no_mem_en", n_en, 32'd0);

    // Stall counter saturates.
    apply_stimulus(1'b1, 32'h70, 1'b0, 1'b0, 32'h0, 32'h0);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    step();
    check_output("t6_sat_c1", stall_cnt, 32'hFFFF_FFFF);
    step();
    check_output("t6_sat_c2", stall_cnt, 32'hFFFF_FFFF);
    step();
    check_output("t6_sat_c3", stall_cnt, 32'hFFFF_FFFF);
    step();
    check_output("t6_if_valid", {31'b0, if_valid}, 32'h1);
    check_output("t6_if_rdata", if_rdata, 32'hC0DE0070);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
